// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the req/ack handshake blocks
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } hs_state_t;

    localparam int SYNC_MIN = 2;

endpackage

// File: rtl/cdc_handshake_tx_ack_sync.sv
// rtl/cdc_handshake_tx_ack_sync.sv - multi-flop synchronizer for a single asynchronous level
module ack_sync
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ack_async,
    output logic ack_s
);

    // Fewer than two stages cannot settle metastability, so clamp upward.
    localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ack_async};
        end
    end

    assign ack_s = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a 4-phase req/ack crossing with optional phase timeout
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_out,
    input  logic                  ack_async,
    output logic                  done,
    output logic                  timeout_err
);

    hs_state_t state;
    logic      ack_s;

    ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk       (clk),
        .reset     (reset),
        .ack_async (ack_async),
        .ack_s     (ack_s)
    );

    // A lingering ack from a previous or aborted handshake blocks new words.
    assign in_ready = (state == IDLE) && !ack_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_out <= in_data;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    req_out <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : gen_timeout
            localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

            logic          phase_start;
            logic          in_wait;
            logic [CW-1:0] phase_cnt;

            assign phase_start = (state == SETUP) || ((state == REQ) && ack_s);
            assign in_wait     = (state == REQ) || (state == RELEASE);

            // Flag only; the handshake keeps waiting so a slow remote still completes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    phase_cnt   <= '0;
                    timeout_err <= 1'b0;
                end else if (phase_start) begin
                    phase_cnt <= '0;
                end else if (in_wait && (phase_cnt != LIMIT)) begin
                    phase_cnt <= phase_cnt + 1'b1;
                    if (phase_cnt == LIMIT - 1'b1) begin
                        timeout_err <= 1'b1;
                    end
                end
            end
        end else begin : gen_no_timeout
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - scoreboard bench for cdc_handshake_tx with a behavioural remote
module tb_cdc_handshake_tx;

    localparam int DW = 12;
    localparam int S  = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          req_out;
    logic          ack_async;
    logic          done;
    logic          timeout_err;

    logic auto_ack   = 1'b0;
    logic man_ack    = 1'b0;
    logic remote_ack = 1'b0;
    assign ack_async = auto_ack ? remote_ack : man_ack;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int rst_edge = 0;
    int n_push   = 0;
    int n_done   = 0;
    int wait_n   = 0;

    bit            samp[int];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;
    bit            mon_on    = 1'b0;
    bit            prev_done = 1'b0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .req_out     (req_out),
        .ack_async   (ack_async),
        .done        (done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Synchronized ack as seen after edge cyc: the level sampled S-1 edges earlier,
    // or 0 if that sample predates the most recent reset edge.
    function automatic bit ack_s_exp();
        int idx;
        idx = cyc - S + 1;
        return (idx > rst_edge) && samp.exists(idx) && samp[idx];
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        samp[cyc] = ack_async;
        if (reset) begin
            rst_edge = cyc;
            exp_q.delete();
            last_data = '0;
        end
    end

    // Remote domain: follows req_out after 0..3 extra edges.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack && (remote_ack != req_out)) begin
                if (wait_n == 0) begin
                    remote_ack = req_out;
                    wait_n = $urandom_range(0, 3);
                end else begin
                    wait_n = wait_n - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on && !reset) begin
            if (exp_q.size() != 0) check("data_out_held", data_out, exp_q[0]);
            else                   check("data_out_kept", data_out, last_data);
            if (done) begin
                check("done_single", prev_done, 0);
                check("done_has_word", exp_q.size() != 0, 1);
                check("done_req_low", req_out, 0);
                if (exp_q.size() != 0) begin
                    last_data = exp_q.pop_front();
                    n_done++;
                end
            end
            if (exp_q.size() == 0) check("req_idle", req_out, 0);
            check("in_ready", in_ready, (exp_q.size() == 0) && !ack_s_exp());
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, output bit acc);
        @(negedge clk);
        #1;
        reset    = r;
        in_valid = v;
        in_data  = d;
        acc      = 1'b0;
        if (v && !r && in_ready) begin
            exp_q.push_back(d);
            n_push++;
            acc = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit a;
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) drive(1'b0, '0, 1'b0, a);
        check(name, exp_q.size(), 0);
        repeat (4) drive(1'b0, '0, 1'b0, a);
    endtask

    initial begin
        bit acc;
        bit second_sent;
        bit seen;
        int acc_edge, ack_rise, ack_fall, rise_edge, phase, k;

        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit second_sent;
        bit seen;
        int acc_edge, ack_rise, ack_fall, rise_edge, phase, k;

        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'hABC;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", req_out, 0);
            check("rst_data", data_out, 0);
            check("rst_done", done, 0);
            check("rst_terr", timeout_err, 0);
        end
        drive(1'b0, '0, 1'b0, acc);
        mon_on = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Single transfer with a hand-driven remote, second word waiting behind it.
        drive(1'b1, 12'h5A3, 1'b0, acc);
        check("accept_5a3", acc, 1);
        acc_edge    = cyc + 1;
        second_sent = 1'b0;
        phase       = 0;
        ack_rise    = 0;
        ack_fall    = 0;
        for (int i = 0; i < 60 && phase < 6; i++) begin
            drive(!second_sent, 12'h001, 1'b0, acc);
            if (acc) second_sent = 1'b1;
            case (phase)
                0: if (req_out) begin
                    check("req_rise_edge", cyc, acc_edge + 1);
                    check("data_at_req", data_out, 12'h5A3);
                    phase = 1;
                end
                1: begin
                    man_ack  = 1'b1;
                    ack_rise = cyc;
                    phase    = 2;
                end
                2: if (!req_out) begin
                    check("req_fall_latency", cyc - ack_rise, S + 1);
                    phase = 3;
                end
                3: begin
                    check("data_in_release", data_out, 12'h5A3);
                    man_ack  = 1'b0;
                    ack_fall = cyc;
                    phase    = 4;
                end
                4: if (done) begin
                    check("done_latency", cyc - ack_fall, S + 1);
                    check("done_ready", in_ready, 1);
                    check("done_data", data_out, 12'h5A3);
                    phase = 5;
                end
                default: begin
                    check("done_one_cycle", done, 0);
                    check("second_captured", data_out, 12'h001);
                    phase = 6;
                end
            endcase
        end
        check("directed_complete", phase, 6);
        auto_ack = 1'b1;
        wait_idle("idle_after_001");

        // Spurious ack while idle.
        auto_ack = 1'b0;
        man_ack  = 1'b1;
        repeat (S) drive(1'b0, '0, 1'b0, acc);
        check("spur_not_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 12'h7E7, 1'b0, acc);
            check("spur_no_capture", acc, 0);
        end
        drive(1'b0, '0, 1'b0, acc);
        man_ack = 1'b0;
        drive(1'b0, '0, 1'b0, acc);
        check("spur_release_1", in_ready, 0);
        drive(1'b0, '0, 1'b0, acc);
        check("spur_release_2", in_ready, 1);
        check("spur_data_kept", data_out, 12'h001);

        // Randomized traffic against the behavioural remote.
        auto_ack = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) != 0, DW'($urandom), 1'b0, acc);
        end
        wait_idle("idle_after_random");
        check("random_all_done", n_done, n_push);
        check("random_no_timeout", timeout_err, 0);

        // Remote never answers.
        auto_ack = 1'b0;
        drive(1'b1, 12'h3C3, 1'b0, acc);
        check("accept_3c3", acc, 1);
        seen      = 1'b0;
        rise_edge = 0;
        k         = 0;
        for (int i = 0; i < 30 && k < TO + 5; i++) begin
            drive(1'b0, '0, 1'b0, acc);
            if (!seen && req_out) begin
                seen      = 1'b1;
                rise_edge = cyc;
            end
            if (seen) begin
                k = cyc - rise_edge;
                check("timeout_err", timeout_err, k >= TO);
                check("timeout_req_hold", req_out, 1);
            end
        end
        check("timeout_req_seen", seen, 1);

        // Reset in REQ with the remote acking.
        drive(1'b0, '0, 1'b1, acc);
        man_ack = 1'b1;
        drive(1'b0, '0, 1'b0, acc);
        check("midrst_req", req_out, 0);
        check("midrst_data", data_out, 0);
        check("midrst_terr", timeout_err, 0);
        check("midrst_done", done, 0);
        repeat (S - 1) drive(1'b0, '0, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, acc);
            check("midrst_ack_block", in_ready, 0);
        end
        man_ack = 1'b0;
        drive(1'b0, '0, 1'b0, acc);
        check("midrst_release_1", in_ready, 0);
        drive(1'b0, '0, 1'b0, acc);
        check("midrst_release_2", in_ready, 1);

        auto_ack = 1'b1;
        drive(1'b1, 12'hFED, 1'b0, acc);
        check("accept_fed", acc, 1);
        wait_idle("idle_after_fed");
        check("post_reset_xfer", last_data, 12'hFED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-domain end of a 4-phase req/ack clock-domain crossing.
- Accepts one data word from local logic and holds it stable on `data_out`.
- Raises `req_out` toward the remote domain, then waits for the remote `ack` (asynchronous to `clk`) to rise and fall before taking the next word.
- Pairs with the existing double-flop synchronizer on the receiving side. Used to pass wave-generator settings (frequency/mode words) across clock domains.

Parameters:
- DATA_WIDTH, 12, width of the transferred word.
- SYNC_STAGES, 2, flip-flop stages on `ack_async` before use (minimum 2).
- TIMEOUT_CYCLES, 0, `clk` cycles allowed per handshake phase before the error flag sets; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  local word available on `in_data`.
- in_data  input  DATA_WIDTH  word to transfer.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  DATA_WIDTH  word driven to the remote domain; stable for the whole handshake.
- req_out  output  1  request to the remote domain; driven directly from a flop.
- ack_async  input  1  acknowledge from the remote domain, asynchronous.
- done  output  1  one-cycle pulse when a handshake completes.
- timeout_err  output  1  sticky error flag.

Behaviour:
- **Reset:** reset is synchronous and active-high; `clk` is the only clock. While reset is high at an edge:
  - state goes to IDLE;
  - `req_out`=0, `data_out`=0, `done`=0, `timeout_err`=0;
  - the sync chain and timeout counter clear to 0.
- **Reset mid-operation:** `req_out` drops immediately at that edge. The block then waits in IDLE until the synchronized ack reads 0.
- **ack synchronization:** `ack_async` passes through SYNC_STAGES flops to give `ack_s`. Only `ack_s` is used internally.
- **in_ready:** combinational, = (state==IDLE) && !`ack_s`.
- **FSM states:** IDLE, SETUP, REQ, RELEASE.
  - IDLE: on `in_valid` && `in_ready` at edge N, capture `in_data` into `data_out` and go to SETUP.
  - SETUP: one cycle, so data settles before the request. Set `req_out`=1 at edge N+1 and go to REQ.
  - REQ: hold `req_out`=1. When `ack_s`=1, clear `req_out` at that edge and go to RELEASE.
  - RELEASE: hold `req_out`=0. When `ack_s`=0, pulse `done`=1 for one cycle at that edge and return to IDLE.
- **data_out:** changes only at an accepting edge. It is held from SETUP through RELEASE and afterwards until the next accept.
- **Minimum handshake length:** with an immediate remote ack, 2 + 2×SYNC_STAGES plus the remote latency.
- **No back-to-back acceptance:** `in_ready`=0 from SETUP until IDLE is re-entered with `ack_s`=0. `in_valid` asserted while not ready is ignored; no queueing.
- **ack glitches:**
  - `ack_s` rising while in IDLE or SETUP: no state change; `in_ready` stays low while `ack_s`=1.
  - `ack_s` falling in REQ before it ever rose: ignored.
- **Timeout** (TIMEOUT_CYCLES>0):
  - A counter of width $clog2(TIMEOUT_CYCLES+1) resets on entry to REQ and on entry to RELEASE, and increments each cycle spent in those states.
  - When the counter equals TIMEOUT_CYCLES, `timeout_err` sets and stays set until reset.
  - The FSM keeps waiting; the handshake is not aborted.
  - The counter saturates and does not wrap.
  - With TIMEOUT_CYCLES=0, the counter logic is absent and `timeout_err` is tied 0.
- **Simultaneous events:** reset has priority over everything. `done` and acceptance never occur in the same cycle, because `done` exits to IDLE and acceptance requires already being in IDLE.

Decomposition:
- Shared package `cdc_pkg`:
  - state enum type `hs_state_t` (IDLE, SETUP, REQ, RELEASE);
  - constant `SYNC_MIN=2`.
- Sub-module `ack_sync`: parameterized SYNC_STAGES flop chain with synchronous active-high reset. It is the same structure as the team's double-flop synchronizer, so it can be reused by the receiver-side block for `req`.

Test Plan:
- **Reset values:** hold reset 3 cycles with `in_valid`=1, `in_data`=12'hABC → `req_out`=0, `data_out`=0, `in_ready`=1 after release, `done` never pulses.
- **Single transfer:**
  - Stimulus: `in_data`=12'h5A3 accepted at edge N; remote model raises ack 1 cycle after seeing `req_out`, drops it 1 cycle after `req_out` falls.
  - Response: `data_out`=12'h5A3 from N; `req_out`=1 from N+1; `req_out` falls 2 cycles after the ack rise; `done` is a single pulse 2 cycles after the ack fall; `in_ready`=1 the same cycle.
- **Back-pressure:** second word 12'h001 presented continuously during a handshake → not captured until `in_ready`; `data_out` stays 12'h5A3 through RELEASE, then becomes 12'h001.
- **Spurious ack:** `ack_async` held 1 while in IDLE → `in_ready`=0, no capture. Release ack → `in_ready`=1 after 2 cycles.
- **Timeout:** TIMEOUT_CYCLES=8 and remote never acks → `timeout_err` rises on the 8th cycle in REQ and stays 1. `req_out` stays 1.
- **Reset mid-handshake:** assert reset during REQ → `req_out`=0 next edge, `data_out`=0. With ack still high, `in_ready` stays 0 until ack is low for 2 cycles.
